// File: rtl/serial_add_sub_if.sv
//==============================================================================
// Module   : serial_add_sub_if
// Purpose  : Operand/result handshake bundle for the serial add/sub block.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface serial_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero, negative
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_sub.sv
//==============================================================================
// Module   : serial_add_sub
// Purpose  : Multi-cycle two's-complement adder/subtractor, CHUNK bits/cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_sub_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic             r_out_valid;

    logic [CHUNK:0]         w_sum;
    logic [WIDTH+CHUNK-1:0] w_cat;
    logic [WIDTH-1:0]       w_work_next;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_msb_cin;

    // Operands shift right each cycle so the active chunk is always at bit 0;
    // sums enter the working register from the top, leaving chunk 0 at the
    // bottom after N cycles.
    assign w_accept    = (r_state == S_IDLE) && bus.in_valid;
    assign w_last      = (r_state == S_RUN) && (r_cnt == C_LAST);
    assign w_sum       = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_y[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, r_carry};
    assign w_cat       = {w_sum[CHUNK-1:0], r_work};
    assign w_work_next = w_cat[WIDTH+CHUNK-1:CHUNK];
    // Carry into the MSB recovered from the MSB's own sum bit and operands.
    assign w_msb_cin   = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_y[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)     w_state_next = S_RUN;
            S_RUN:   if (r_cnt == C_LAST)  w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready)    w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_y         <= '0;
            r_work      <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_y     <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_work  <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_y     <= r_y >> CHUNK;
            r_carry <= w_sum[CHUNK];
            r_work  <= w_work_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cnt       <= '0;
                r_result    <= w_work_next;
                r_cout      <= w_sum[CHUNK];
                r_ovf       <= w_msb_cin ^ w_sum[CHUNK];
                r_zero      <= (w_work_next == '0);
                r_neg       <= w_work_next[WIDTH-1];
                r_out_valid <= 1'b1;
            end
        end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
//==============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Self-checking bench for serial_add_sub at CHUNK = 8, 1, 4, 32.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_add_sub;
    localparam int W = 32;

    logic clk;
    logic rst;

    logic [3:0]   drv_valid;
    logic [3:0]   drv_sub;
    logic [3:0]   drv_ordy;
    logic [W-1:0] drv_a [4];
    logic [W-1:0] drv_b [4];

    logic         obs_in_ready  [4];
    logic         obs_out_valid [4];
    logic [W-1:0] obs_result    [4];
    logic [3:0]   obs_flags     [4];   // {cout, overflow, zero, negative}

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 is the default configuration; 1..3 form the parameter sweep.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int C = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        serial_add_sub_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = drv_valid[g];
        assign bus.a         = drv_a[g];
        assign bus.b         = drv_b[g];
        assign bus.sub       = drv_sub[g];
        assign bus.out_ready = drv_ordy[g];
        assign obs_in_ready[g]  = bus.in_ready;
        assign obs_out_valid[g] = bus.out_valid;
        assign obs_result[g]    = bus.result;
        assign obs_flags[g]     = {bus.cout, bus.overflow, bus.zero, bus.negative};
        serial_add_sub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 32 : (idx == 2) ? 8 : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to WIDTH bits and flags.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, ue, se;
        logic [63:0] bits;
        logic c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ue = s ? (ua - ub) : (ua + ub);
        se = s ? (sa - sb) : (sa + sb);
        bits = ue;
        r = bits[W-1:0];
        c = s ? (ua >= ub) : (ue >= 64'h1_0000_0000);
        v = (se > 64'sd2147483647) || (se < -64'sd2147483648);
        f = {c, v, (r == '0), r[W-1]};
    endfunction

    // Called #1 after a rising edge with the instance idle.
    task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output logic [W-1:0] r, output logic [3:0] f,
                         output int lat);
        check($sformatf("in_ready_idle[%0d]", idx), obs_in_ready[idx], 1);
        drv_a[idx] = a;
        drv_b[idx] = b;
        drv_sub[idx] = s;
        drv_valid[idx] = 1'b1;
        @(posedge clk); #1;
        drv_valid[idx] = 1'b0;
        lat = 0;
        while (!obs_out_valid[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = obs_result[idx];
        f = obs_flags[idx];
        drv_ordy[idx] = 1'b1;
        @(posedge clk); #1;
        drv_ordy[idx] = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0] r, er, a, b;
        logic [3:0]   f, ef;
        logic         s;
        int           lat;

        vecs[0] = '{32'd39,        32'd136,       1'b1, 32'hFFFF_FF9F, 4'b0001};
        vecs[1] = '{32'd0,         32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 4'b0001};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, 4'b1010};
        vecs[3] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 4'b0101};
        vecs[4] = '{32'd5,         32'd3,         1'b1, 32'h0000_0002, 4'b1000};
        vecs[5] = '{32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 4'b1100};
        vecs[6] = '{32'd0,         32'd0,         1'b1, 32'h0000_0000, 4'b1010};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110};

        drv_valid = '0;
        drv_sub   = '0;
        drv_ordy  = '0;
        for (int i = 0; i < 4; i++) begin
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_in_ready[%0d]", i),  obs_in_ready[i], 1);
            check($sformatf("rst_out_valid[%0d]", i), obs_out_valid[i], 0);
            check($sformatf("rst_result[%0d]", i),    obs_result[i], 0);
            check($sformatf("rst_flags[%0d]", i),     obs_flags[i], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table on every configuration.
        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 8; v++) begin
                do_op(i, vecs[v].a, vecs[v].b, vecs[v].s, r, f, lat);
                check($sformatf("vec%0d_result[%0d]", v, i), r, vecs[v].r);
                check($sformatf("vec%0d_flags[%0d]", v, i),  f, vecs[v].f);
                check($sformatf("vec%0d_latency[%0d]", v, i), lat, lat_of(i));
                check($sformatf("vec%0d_drop[%0d]", v, i), obs_out_valid[i], 0);
            end
        end

        // Random operands against the reference model.
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 20; n++) begin
                a = $urandom;
                b = (n % 5 == 0) ? a : 32'($urandom);
                s = 1'($urandom_range(0, 1));
                model(a, b, s, er, ef);
                do_op(i, a, b, s, r, f, lat);
                check($sformatf("rnd_result[%0d]", i),  r, er);
                check($sformatf("rnd_flags[%0d]", i),   f, ef);
                check($sformatf("rnd_latency[%0d]", i), lat, lat_of(i));
            end
        end

        // Backpressure: result held while out_ready is low, new operands ignored.
        model(32'h1234_5678, 32'h1111_1111, 1'b0, er, ef);
        drv_a[0] = 32'h1234_5678;
        drv_b[0] = 32'h1111_1111;
        drv_sub[0] = 1'b0;
        drv_valid[0] = 1'b1;
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        lat = 0;
        while (!obs_out_valid[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 4);
        for (int c = 0; c < 3; c++) begin
            drv_a[0] = $urandom;
            drv_b[0] = $urandom;
            drv_sub[0] = 1'b1;
            drv_valid[0] = 1'b1;
            @(posedge clk); #1;
            check("bp_result_hold", obs_result[0], er);
            check("bp_flags_hold", obs_flags[0], ef);
            check("bp_out_valid_hold", obs_out_valid[0], 1);
            check("bp_in_ready_low", obs_in_ready[0], 0);
        end
        drv_valid[0] = 1'b0;
        drv_ordy[0] = 1'b1;
        @(posedge clk); #1;
        drv_ordy[0] = 1'b0;
        check("bp_release_out_valid", obs_out_valid[0], 0);
        check("bp_release_in_ready", obs_in_ready[0], 1);
        check("bp_release_result", obs_result[0], er);
        repeat (6) @(posedge clk);
        #1;
        check("bp_no_phantom_op", obs_out_valid[0], 0);
        check("bp_still_idle", obs_in_ready[0], 1);

        // Reset asserted asynchronously two cycles into RUN.
        drv_a[0] = 32'hFFFF_FFFF;
        drv_b[0] = 32'd1;
        drv_sub[0] = 1'b0;
        drv_valid[0] = 1'b1;
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", obs_in_ready[0], 1);
        check("mid_rst_out_valid", obs_out_valid[0], 0);
        check("mid_rst_result", obs_result[0], 0);
        check("mid_rst_flags", obs_flags[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_out_valid", obs_out_valid[0], 0);
        do_op(0, 32'd5, 32'd3, 1'b1, r, f, lat);
        check("post_rst_result", r, 32'd2);
        check("post_rst_cout", f[3], 1);
        check("post_rst_latency", lat, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor; successor to the 32-bit ripple add/sub block.
- Processes CHUNK bits per clock over WIDTH/CHUNK cycles, which trades latency for a short carry chain.
- Uses a valid/ready handshake on input and output.
- Produces carry, overflow, zero and negative flags for the ALU/datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH >= 2.
- CHUNK, 8, bits added per RUN cycle; WIDTH must be an integer multiple of CHUNK (1 <= CHUNK <= WIDTH).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B (computed as A + ~B + 1).
- out_valid  output  1  result/flags valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].

Behaviour:
- N = WIDTH/CHUNK. States: IDLE, RUN, DONE. Internal chunk counter of width clog2(N) (minimum 1).
- Reset (async, any state, including mid-RUN):
  - State goes to IDLE and counter to 0.
  - result, cout, overflow, zero, negative and out_valid go to 0.
  - Any in-flight operation is discarded; no out_valid is produced for it.
  - in_ready = 1 while in IDLE, including during reset.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready, latch:
    - a;
    - y = b XOR {WIDTH{sub}};
    - carry = sub;
    - counter = 0.
  - Then go to RUN. Inputs are not sampled again until the next IDLE.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle computes {c, s} = a[k*CHUNK +: CHUNK] + y[k*CHUNK +: CHUNK] + carry, with k = counter.
  - s is stored in the working register slice k; carry <= c; counter increments.
  - On the last chunk (k = N-1):
    - Capture the carry into bit WIDTH-1 (from the internal chunk ripple).
    - Transfer the working register to result.
    - Set cout, overflow, zero and negative.
    - Go to DONE.
- Latency: out_valid rises exactly N rising edges after the accept edge (N=4 at defaults; N=1 when CHUNK=WIDTH; N=WIDTH when CHUNK=1).
- DONE:
  - out_valid = 1, in_ready = 0.
  - result and all flags hold stable.
  - On out_ready high: out_valid <= 0, go to IDLE. No same-cycle accept of a new operand; throughput is one operation per N+2 cycles when out_ready is held high.
- result and flags are registered and are unchanged from DONE until the next final-chunk update. Partial sums are never visible on result.
- in_valid is ignored outside IDLE; out_ready is ignored outside DONE.
- Wrap-around: arithmetic is modulo 2^WIDTH; the bit shifted out appears only on cout.

Test Plan:
- Subtract, sub=1, a=39, b=136 (WIDTH=32, CHUNK=8) -> after 4 cycles: result=0xFFFFFF9F, cout=0, overflow=0, negative=1, zero=0.
- Add, sub=0, a=0, b=0xFFFFFFFF -> result=0xFFFFFFFF, cout=0, overflow=0, negative=1.
- Add carry wrap, a=0xFFFFFFFF, b=1 -> result=0, cout=1, zero=1, overflow=0. Signed overflow, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, negative=1, cout=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid while pulsing in_valid with new operands.
  - Required: result and flags stable, out_valid held, in_ready=0, new operands ignored.
  - Then out_ready=1 -> out_valid drops the next cycle and in_ready=1.
- Reset mid-RUN:
  - Assert rst asynchronously after 2 RUN cycles.
  - Required: immediately state IDLE, all outputs 0, in_ready=1.
  - A fresh op 5-3 after release gives result=2, cout=1.
- Parameter sweep with CHUNK=1, CHUNK=4 and CHUNK=WIDTH=32, random a/b/sub: result and flags match a reference model, and latency equals 32, 8 and 1 cycles respectively.
